// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic register pipeline of DEPTH stages that only advances on a
//   prescaled strobe. Every stage carries a data word and a valid bit; an
//   empty stage always accepts from its predecessor, so bubbles collapse
//   even while the output is stalled. flush discards all contents
//   synchronously without disturbing the prescaler.
//
// Parameters
//   WIDTH  data width in bits (>=1)
//   DEPTH  number of register stages (>=1)
//   DIV    advance period in clk cycles (>=1; 1 = every cycle)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    upstream data
//   in_valid   upstream data valid
//   in_ready   block accepts in_data this cycle
//   out_data   last-stage data
//   out_valid  out_data offered this cycle
//   out_ready  downstream accepts
//   flush      synchronous discard of all contents
//   tick       registered advance strobe, one cycle in every DIV
//   occupancy  number of valid stages
module pipe_stage_elastic #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int DIV   = 125000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       tick,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  // A one-bit counter is kept for DIV=1 so the prescaler never has zero width.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]    cnt_r;
  logic             tick_r;
  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [DEPTH-1:0] r_s;
  logic             advance_s;

  function automatic logic [OW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [OW-1:0] sum;
    sum = {OW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + OW'(bits[i]);
    end
    return sum;
  endfunction

  // Prescaler: counts 0..DIV-1 and raises tick on the edge that ends a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == CNT_MAX);
      if (cnt_r == CNT_MAX) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Ready chain: a stage can load when it is empty or everything ahead moves.
  always_comb begin
    r_s = {DEPTH{1'b0}};
    r_s[DEPTH-1] = ~v_r[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r_s[i] = ~v_r[i] | r_s[i+1];
    end
  end

  // Handshakes exist only on tick cycles and are suppressed while flushing.
  always_comb begin
    advance_s = tick_r & ~flush;
    in_ready  = advance_s & r_s[0];
    out_valid = advance_s & v_r[DEPTH-1];
    out_data  = d_r[DEPTH-1];
    tick      = tick_r;
    occupancy = popcount(v_r);
  end

  // Stage registers: flush clears valids only; on a tick, ready stages shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        d_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      v_r <= {DEPTH{1'b0}};
    end else if (tick_r) begin
      if (r_s[0]) begin
        v_r[0] <= in_valid & in_ready;
        d_r[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r_s[i]) begin
          v_r[i] <= v_r[i-1];
          d_r[i] <= d_r[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: directed scenarios plus a randomized run
// checked against a queue-based model of item positions.
module tb_pipe_stage_elastic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       flush;
  bit         sel;
  int         cur_div;
  int         errors = 0;
  int         checks = 0;

  logic       ir1, ov1, tk1, ir5, ov5, tk5;
  logic [3:0] od1, od5;
  logic [1:0] oc1, oc5;
  logic       o_ir, o_ov, o_tk;
  logic [3:0] o_od;
  logic [1:0] o_oc;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(4), .DEPTH(3), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .flush(flush), .tick(tk1), .occupancy(oc1));

  pipe_stage_elastic #(.WIDTH(4), .DEPTH(3), .DIV(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir5), .out_data(od5), .out_valid(ov5), .out_ready(out_ready),
    .flush(flush), .tick(tk5), .occupancy(oc5));

  assign o_ir = sel ? ir5 : ir1;
  assign o_ov = sel ? ov5 : ov1;
  assign o_tk = sel ? tk5 : tk1;
  assign o_od = sel ? od5 : od1;
  assign o_oc = sel ? oc5 : oc1;

  // Reset both DUTs and release on a falling edge; zero edges seen afterwards.
  task automatic reset_dut(input bit s);
    sel = s; cur_div = s ? 5 : 1;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    sel = 1'b0; cur_div = 1;
    in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", o_ir); end
    checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", o_ov); end
    checks++; if (o_oc !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", o_oc); end
    checks++; if (o_od !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", o_od); end
    checks++; if (o_tk !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", o_tk); end
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (o_tk !== 1'b0) begin errors++; $display("FAIL tick_before_edge: got %0b want 0", o_tk); end
    @(negedge clk);
    checks++; if (o_tk !== 1'b1) begin errors++; $display("FAIL tick_first_edge: got %0b want 1", o_tk); end
  endtask

  // Three items back to back, each offered three cycles after acceptance.
  task automatic test_back_to_back(input logic [3:0] b);
    @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3); in_data = b + 4'(c); out_ready = 1'b1; flush = 1'b0;
      #1;
      checks++; if (o_ir !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d: got %0b want 1", c, o_ir); end
      checks++; if (o_ov !== 1'((c >= 3) && (c < 6))) begin errors++; $display("FAIL b2b_out_valid c=%0d: got %0b", c, o_ov); end
      if ((c >= 3) && (c < 6)) begin
        checks++; if (o_od !== b + 4'(c - 3)) begin errors++; $display("FAIL b2b_out_data c=%0d: got %0h want %0h", c, o_od, b + 4'(c - 3)); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_stall;
    int occ_t [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
    bit exp_ir, exp_ov;
    logic [3:0] exp_od;
    reset_dut(1'b0);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c <= 5); in_data = (c < 3) ? 4'(5 + c) : 4'h8; out_ready = (c >= 5); flush = 1'b0;
      exp_ir = !((c == 3) || (c == 4));
      exp_ov = (c >= 3) && (c <= 8);
      exp_od = (c <= 5) ? 4'h5 : 4'(c);
      #1;
      checks++; if (o_ir !== exp_ir) begin errors++; $display("FAIL full_in_ready c=%0d: got %0b want %0b", c, o_ir, exp_ir); end
      checks++; if (o_ov !== exp_ov) begin errors++; $display("FAIL full_out_valid c=%0d: got %0b want %0b", c, o_ov, exp_ov); end
      checks++; if (o_oc !== 2'(occ_t[c])) begin errors++; $display("FAIL full_occupancy c=%0d: got %0d want %0d", c, o_oc, occ_t[c]); end
      if (exp_ov) begin
        checks++; if (o_od !== exp_od) begin errors++; $display("FAIL full_out_data c=%0d: got %0h want %0h", c, o_od, exp_od); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bubble;
    int occ_t [10] = '{0, 1, 1, 1, 2, 3, 3, 2, 1, 0};
    logic [3:0] dv [10] = '{4'hA, 4'h0, 4'h0, 4'hB, 4'hC, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
    bit exp_ir, exp_ov;
    logic [3:0] exp_od;
    reset_dut(1'b0);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0) || ((c >= 3) && (c <= 5)); in_data = dv[c]; out_ready = (c >= 6); flush = 1'b0;
      exp_ir = (c != 5);
      exp_ov = (c >= 3) && (c <= 8);
      exp_od = (c <= 6) ? 4'hA : ((c == 7) ? 4'hB : 4'hC);
      #1;
      checks++; if (o_ir !== exp_ir) begin errors++; $display("FAIL bubble_in_ready c=%0d: got %0b want %0b", c, o_ir, exp_ir); end
      checks++; if (o_ov !== exp_ov) begin errors++; $display("FAIL bubble_out_valid c=%0d: got %0b want %0b", c, o_ov, exp_ov); end
      checks++; if (o_oc !== 2'(occ_t[c])) begin errors++; $display("FAIL bubble_occupancy c=%0d: got %0d want %0d", c, o_oc, occ_t[c]); end
      if (exp_ov) begin
        checks++; if (o_od !== exp_od) begin errors++; $display("FAIL bubble_out_data c=%0d: got %0h want %0h", c, o_od, exp_od); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_prescale;
    bit tick_e;
    reset_dut(1'b1);
    for (int k = 0; k < 27; k++) begin
      in_valid = (k <= 5); in_data = 4'h9; out_ready = 1'b1; flush = 1'b0;
      tick_e = (k > 0) && (k % 5 == 0);
      #1;
      checks++; if (o_tk !== tick_e) begin errors++; $display("FAIL div5_tick k=%0d: got %0b want %0b", k, o_tk, tick_e); end
      checks++; if (o_ir !== tick_e) begin errors++; $display("FAIL div5_in_ready k=%0d: got %0b want %0b", k, o_ir, tick_e); end
      checks++; if (o_ov !== 1'(k == 20)) begin errors++; $display("FAIL div5_out_valid k=%0d: got %0b want %0b", k, o_ov, (k == 20)); end
      if (k == 20) begin
        checks++; if (o_od !== 4'h9) begin errors++; $display("FAIL div5_out_data: got %0h want 9", o_od); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush;
    bit tick_e;
    int exp_occ;
    reset_dut(1'b1);
    for (int k = 0; k < 27; k++) begin
      in_valid = (k == 5) || (k == 10) || (k == 20);
      in_data = (k == 5) ? 4'h3 : ((k == 10) ? 4'h4 : 4'hF);
      out_ready = 1'b0; flush = (k == 20);
      tick_e = (k > 0) && (k % 5 == 0);
      exp_occ = (k <= 5) ? 0 : ((k <= 10) ? 1 : ((k <= 20) ? 2 : 0));
      #1;
      checks++; if (o_tk !== tick_e) begin errors++; $display("FAIL flush_tick k=%0d: got %0b want %0b", k, o_tk, tick_e); end
      checks++; if (o_ir !== 1'(tick_e && (k != 20))) begin errors++; $display("FAIL flush_in_ready k=%0d: got %0b", k, o_ir); end
      checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL flush_out_valid k=%0d: got %0b want 0", k, o_ov); end
      checks++; if (o_oc !== 2'(exp_occ)) begin errors++; $display("FAIL flush_occupancy k=%0d: got %0d want %0d", k, o_oc, exp_occ); end
      if ((k >= 16) && (k <= 25)) begin
        checks++; if (o_od !== 4'h3) begin errors++; $display("FAIL flush_data_kept k=%0d: got %0h want 3", k, o_od); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_midstream;
    reset_dut(1'b0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 4'(5 + c); out_ready = 1'b0;
      @(negedge clk);
    end
    #1;
    checks++; if (o_oc !== 2'd3) begin errors++; $display("FAIL mid_full_occupancy: got %0d want 3", o_oc); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_ir !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %0b want 0", o_ir); end
    checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %0b want 0", o_ov); end
    checks++; if (o_oc !== 2'd0) begin errors++; $display("FAIL mid_reset_occupancy: got %0d want 0", o_oc); end
    checks++; if (o_od !== 4'h0) begin errors++; $display("FAIL mid_reset_out_data: got %0h want 0", o_od); end
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (o_tk !== 1'b0) begin errors++; $display("FAIL mid_release_tick: got %0b want 0", o_tk); end
    #1;
    test_back_to_back(4'hA);
  endtask

  // Random traffic against a model holding each item's stage position.
  task automatic test_random(input bit s, input int n);
    int pos[$]; int np[$];
    logic [3:0] dat[$]; logic [3:0] nd[$];
    bit occ [3];
    bit tick_e, full, has_last, exp_ir, exp_ov, gap, iv, ordy, fl;
    logic [3:0] id;
    reset_dut(s);
    for (int k = 0; k < n; k++) begin
      iv = ($urandom_range(0, 3) != 0); id = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 2) != 0); fl = ($urandom_range(0, 15) == 0);
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
      #1;
      tick_e   = (k > 0) && (k % cur_div == 0);
      full     = (pos.size() == 3);
      has_last = (pos.size() > 0) && (pos[0] == 2);
      exp_ir   = tick_e && !fl && !(full && !ordy);
      exp_ov   = tick_e && !fl && has_last;
      checks++; if (o_tk !== tick_e) begin errors++; $display("FAIL rnd_tick k=%0d: got %0b want %0b", k, o_tk, tick_e); end
      checks++; if (o_ir !== exp_ir) begin errors++; $display("FAIL rnd_in_ready k=%0d: got %0b want %0b", k, o_ir, exp_ir); end
      checks++; if (o_ov !== exp_ov) begin errors++; $display("FAIL rnd_out_valid k=%0d: got %0b want %0b", k, o_ov, exp_ov); end
      checks++; if (o_oc !== 2'(pos.size())) begin errors++; $display("FAIL rnd_occupancy k=%0d: got %0d want %0d", k, o_oc, pos.size()); end
      if (exp_ov) begin
        checks++; if (o_od !== dat[0]) begin errors++; $display("FAIL rnd_out_data k=%0d: got %0h want %0h", k, o_od, dat[0]); end
      end
      if (fl) begin
        pos.delete(); dat.delete();
      end else if (tick_e) begin
        np.delete(); nd.delete();
        for (int j = 0; j < 3; j++) occ[j] = 1'b0;
        foreach (pos[i]) occ[pos[i]] = 1'b1;
        for (int i = 0; i < pos.size(); i++) begin
          int p;
          p = pos[i];
          if (p == 2) begin
            if (!ordy) begin np.push_back(2); nd.push_back(dat[i]); end
          end else begin
            gap = 1'b0;
            for (int j = p + 1; j < 3; j++) if (!occ[j]) gap = 1'b1;
            np.push_back((gap || ordy) ? p + 1 : p);
            nd.push_back(dat[i]);
          end
        end
        if (exp_ir && iv) begin np.push_back(0); nd.push_back(id); end
        pos = np; dat = nd;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; flush = 1'b0;
    sel = 1'b0; cur_div = 1;
    @(negedge clk);
    test_reset;
    reset_dut(1'b0);
    test_back_to_back(4'h1);
    test_full_stall;
    test_bubble;
    test_prescale;
    test_flush;
    test_reset_midstream;
    test_random(1'b0, 400);
    test_random(1'b1, 800);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter DIV, default 125000000, advance period in clk cycles (>=1; 1 = every cycle).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  WIDTH  upstream data.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  last-stage data.
REQ-010 SHALL have port out_valid  output  1  out_data offered this cycle.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-013 SHALL have port tick  output  1  registered advance strobe.
REQ-014 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 Prescaler cnt SHALL count 0..DIV-1, wrapping to 0; period exactly DIV cycles.
REQ-016 tick SHALL be registered: set on the edge where cnt==DIV-1, else cleared; high one cycle in every DIV (constantly high for DIV=1).
REQ-017 Each stage i SHALL hold data d[i] and valid bit v[i]; stage 0 is input side, stage DEPTH-1 drives out_data/out_valid.
REQ-018 Ready chain: r[DEPTH-1] = ~v[DEPTH-1] | out_ready; r[i] = ~v[i] | r[i+1]; combinational.
REQ-019 in_ready SHALL equal tick & r[0] & ~flush.
REQ-020 out_valid SHALL equal tick & v[DEPTH-1] & ~flush; out_data = d[DEPTH-1] at all times.
REQ-021 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; no transfer outside tick cycles.
REQ-022 On a tick edge without flush, every stage i with r[i]=1 SHALL load d/v from stage i-1 (stage 0 from in_data/in_valid & in_ready); stages with r[i]=0 hold.
REQ-023 Bubbles SHALL collapse: an empty stage accepts from its predecessor even when downstream is stalled.
REQ-024 Latency: with no backpressure, item accepted on tick n SHALL be offered on tick n+DEPTH.
REQ-025 Order SHALL be preserved; no item duplicated or dropped except by flush/reset.
REQ-026 Full (all v=1) with out_ready=0: in_ready=0; full with out_ready=1 on tick: simultaneous in and out accepted, occupancy unchanged.
REQ-027 flush SHALL act in any cycle: clears all v at next edge, d unchanged, blocks same-cycle in/out transfers; cnt and tick unaffected.
REQ-028 occupancy SHALL equal popcount of v, derived from registered state.
REQ-029 With out_valid high and out_ready low, out_data SHALL remain stable until transferred or flushed.

Reset
REQ-030 rst_n low SHALL immediately clear cnt, tick, all v and all d to 0; in_ready=0, out_valid=0, occupancy=0, out_data=0.
REQ-031 Reset mid-operation SHALL discard all contents; first tick after release occurs DIV edges after first active edge.

Verification
REQ-032 WIDTH=4, DEPTH=3, DIV=1, out_ready=1, send 1,2,3 back-to-back -> out_data 1,2,3 on consecutive cycles, each 3 cycles after acceptance.
REQ-033 DEPTH=3, DIV=1, out_ready=0, in_valid=1 values 5,6,7,8 -> 5,6,7 accepted, in_ready=0 for 8, occupancy=3; raise out_ready -> 5,6,7,8 in order.
REQ-034 DEPTH=3, DIV=1, one item A, out_ready=0 -> A reaches stage 2 after 3 cycles, then two more items accepted (bubble collapse), occupancy=3.
REQ-035 DIV=5 -> tick high 1 of every 5 cycles, first after 5th edge; in_ready/out_valid only high on tick cycles; latency = 3 ticks = 15 cycles.
REQ-036 occupancy=2, flush=1 with in_valid=1 same cycle -> in_ready=0, out_valid=0, next cycle occupancy=0, tick phase unchanged.
REQ-037 rst_n pulsed low mid-stream with occupancy=3 -> outputs 0 immediately, occupancy=0; after release, new stream passes with REQ-032 timing.
